// File: rtl/fixed_dot_product_sched_pkg.sv
// Shared types and helpers for the round-robin dot-product scheduler.
package fixed_dot_product_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int unsigned RR_MAX   = 32;
    localparam int unsigned RR_IDX_W = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of valid[n-1:0] at or after start, searching cyclically.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input int unsigned n,
                                         input int unsigned start);
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            k = start + i;
            if (k >= n) k = k - n;
            if ((i < n) && !res.found && valid[k[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = k[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_dot_product_sched_tag_fifo.sv
// In-order FIFO of issued requester IDs; head tag steers the next returning result.
module fixed_dot_product_sched_tag_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= ptr_inc(wr_q);
            if (pop_ok)  rd_q <= ptr_inc(rd_q);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    // Tag storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fixed_dot_product_sched.sv
// Round-robin scheduler sharing one dot-product datapath between NUM_REQ requesters.
// Optional counters (issue_count, stall_count) with FIXED_DOT_PRODUCT_SCHED_PERF_EN.
module fixed_dot_product_sched
    import fixed_dot_product_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned IN_SIZE      = 4,
    parameter int unsigned OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE),
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ*IN_SIZE*IN_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*IN_SIZE*WEIGHT_WIDTH-1:0] req_weight,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [IN_SIZE*IN_WIDTH-1:0]             dp_data_in,
    output logic                                    dp_data_in_valid,
    input  logic                                    dp_data_in_ready,
    output logic [IN_SIZE*WEIGHT_WIDTH-1:0]         dp_weight,
    output logic                                    dp_weight_valid,
    input  logic                                    dp_weight_ready,
    input  logic [OUT_WIDTH-1:0]                    dp_data_out,
    input  logic                                    dp_data_out_valid,
    output logic                                    dp_data_out_ready,
    output logic [OUT_WIDTH-1:0]                    resp_data,
    output logic [NUM_REQ-1:0]                      resp_valid,
    input  logic [NUM_REQ-1:0]                      resp_ready,
`ifdef FIXED_DOT_PRODUCT_SCHED_PERF_EN
    output logic [NUM_REQ*32-1:0]                   issue_count,
    output logic [31:0]                             stall_count,
`endif
    output logic                                    busy
);
    localparam int unsigned TW = tag_width(NUM_REQ);
    localparam int unsigned DW = IN_SIZE * IN_WIDTH;
    localparam int unsigned WW = IN_SIZE * WEIGHT_WIDTH;
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    state_e          state_q;
    logic [TW-1:0]   grant_q;
    logic [TW-1:0]   rr_q;
    logic            data_sent_q;
    logic            weight_sent_q;

    logic [TW-1:0]   grant_inc;
    logic [NUM_REQ-1:0] grant_oh;
    logic            data_acc;
    logic            weight_acc;
    logic            complete;
    rr_pick_t        idle_pick;
    rr_pick_t        next_pick;

    logic            full;
    logic            empty;
    logic [TW-1:0]   head;
    logic [CW-1:0]   count;
    logic            pop;

    assign dp_data_in       = req_data[DW*int'(grant_q) +: DW];
    assign dp_weight        = req_weight[WW*int'(grant_q) +: WW];
    assign dp_data_in_valid = (state_q == ISSUE) && !data_sent_q && !full;
    assign dp_weight_valid  = (state_q == ISSUE) && !weight_sent_q && !full;

    // Completion fires on the cycle the last outstanding half is accepted.
    always_comb begin
        grant_inc  = (grant_q == TW'(NUM_REQ - 1)) ? '0 : grant_q + TW'(1);
        grant_oh   = NUM_REQ'(1) << grant_q;
        data_acc   = dp_data_in_valid && dp_data_in_ready;
        weight_acc = dp_weight_valid && dp_weight_ready;
        complete   = (state_q == ISSUE) && (data_sent_q || data_acc)
                                        && (weight_sent_q || weight_acc);
        idle_pick  = rr_pick(RR_MAX'(req_valid), NUM_REQ, 32'(rr_q));
        next_pick  = rr_pick(RR_MAX'(req_valid & ~grant_oh), NUM_REQ, 32'(grant_inc));
        req_ready  = complete ? grant_oh : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_q          <= '0;
            data_sent_q   <= 1'b0;
            weight_sent_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_pick.found && !full) begin
                        grant_q <= TW'(idle_pick.idx);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (complete) begin
                        data_sent_q   <= 1'b0;
                        weight_sent_q <= 1'b0;
                        rr_q          <= grant_inc;
                        if (next_pick.found) grant_q <= TW'(next_pick.idx);
                        else                 state_q <= IDLE;
                    end else begin
                        if (data_acc)   data_sent_q   <= 1'b1;
                        if (weight_acc) weight_sent_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fixed_dot_product_sched_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (complete),
        .data_i  (grant_q),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign resp_data         = dp_data_out;
    assign resp_valid        = (NUM_REQ'(1) << head) & {NUM_REQ{dp_data_out_valid && !empty}};
    assign dp_data_out_ready = !empty && resp_ready[head];
    assign pop               = dp_data_out_valid && dp_data_out_ready;
    assign busy              = (state_q == ISSUE) || (count != '0);

    // A result with no tag outstanding means the datapath broke ordering.
    a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst)
        !(dp_data_out_valid && empty));

`ifdef FIXED_DOT_PRODUCT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (complete && (grant_q == TW'(i)))
                    issue_count[32*i +: 32] <= issue_count[32*i +: 32] + 32'd1;
            end
            if ((state_q == ISSUE) && (full || (dp_data_in_valid && !dp_data_in_ready)
                                            || (dp_weight_valid && !dp_weight_ready)))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
